// File: rtl/ahb_pkg.sv
// Shared AHB-lite types and helpers for the SRAM arbiter slice.
package ahb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // A beat only moves data when it is NONSEQ or SEQ.
  function automatic logic is_active(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_rr_grant.sv
// Pure next-grant decision: round-robin between two masters with a per-owner
// beat limit while the other master is waiting.
module ahb_rr_grant #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic [1:0]       req_i,
  input  logic [1:0]       grant_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             accept_i,
  input  logic             ptr_i,    // 1 = master 1 was granted last
  output logic [1:0]       grant_o
);

  localparam logic [CNT_W:0] MAX_V = (CNT_W + 1)'(MAX_BURST);

  logic [CNT_W:0] beats;
  logic           owner_live;

  // Beats already taken by the owner, including the one accepted this edge.
  assign beats      = {1'b0, cnt_i} + {{CNT_W{1'b0}}, accept_i};
  assign owner_live = (grant_i == 2'b01) || (grant_i == 2'b10);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b00: grant_o = 2'b00;
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      default: begin
        if (owner_live && (beats < MAX_V)) grant_o = grant_i;
        else                               grant_o = ptr_i ? 2'b01 : 2'b10;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB-lite arbiter in front of the sram_control slave: address-phase
// mux on grant, write-data mux on the registered data-phase owner.
module ahb_sram_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [1:0]        m_hbusreq,
  output logic [1:0]        m_hgrant,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic [1:0]        m1_htrans,
  input  logic              m0_hwrite,
  input  logic              m1_hwrite,
  input  logic [DATA_W-1:0] m0_hwdata,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m_hready,
  output logic [DATA_W-1:0] m_hrdata,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic [DATA_W-1:0] s_hrdata,
  output logic [1:0]        data_owner
);

  localparam int             CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic [1:0]       grant_q, grant_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       nxt_grant;
  htrans_t          sel_trans;
  logic             accept;

  // Address-phase mux: an ungranted bus looks IDLE to the slave.
  always_comb begin
    sel_trans = IDLE;
    s_haddr   = '0;
    s_hwrite  = 1'b0;
    unique case (grant_q)
      2'b01: begin
        sel_trans = htrans_t'(m0_htrans);
        s_haddr   = m0_haddr;
        s_hwrite  = m0_hwrite;
      end
      2'b10: begin
        sel_trans = htrans_t'(m1_htrans);
        s_haddr   = m1_haddr;
        s_hwrite  = m1_hwrite;
      end
      default: ;
    endcase
  end

  assign s_htrans = sel_trans;
  assign accept   = s_hready && is_active(sel_trans);

  ahb_rr_grant #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_rr (
    .req_i    (m_hbusreq),
    .grant_i  (grant_q),
    .cnt_i    (cnt_q),
    .accept_i (accept),
    .ptr_i    (ptr_q),
    .grant_o  (nxt_grant)
  );

  // Everything is frozen across wait states so the in-flight address holds.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (s_hready) begin
      grant_d = nxt_grant;
      owner_d = is_active(sel_trans) ? grant_q : 2'b00;
      if (grant_d != grant_q) begin
        cnt_d = '0;
        if (grant_d != 2'b00) ptr_d = grant_d[1];
      end else if (accept && (cnt_q < CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q <= 2'b00;
      owner_q <= 2'b00;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    s_hwdata = '0;
    unique case (owner_q)
      2'b01:   s_hwdata = m0_hwdata;
      2'b10:   s_hwdata = m1_hwdata;
      default: ;
    endcase
  end

  assign m_hgrant   = grant_q;
  assign data_owner = owner_q;
  assign m_hready   = s_hready;
  assign m_hrdata   = s_hrdata;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level
// arbitration model for ahb_sram_arbiter.
module tb_ahb_sram_arbiter;

  localparam int MAXB = 4;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  m_hbusreq;
  logic [1:0]  m_hgrant;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m_hready;
  logic [31:0] m_hrdata;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic [31:0] s_hrdata;
  logic [1:0]  data_owner;

  int errs   = 0;
  int checks = 0;

  ahb_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .m_hbusreq(m_hbusreq), .m_hgrant(m_hgrant),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr), .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite), .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .m_hready(m_hready), .m_hrdata(m_hrdata), .s_haddr(s_haddr), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata),
    .data_owner(data_owner)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  // Hold reset for two edges, release mid-cycle; next edge is the first live one.
  task automatic do_reset();
    HRESETn = 1'b0;
    m_hbusreq = 2'b00;
    m0_haddr = '0; m1_haddr = '0; m0_htrans = 2'b00; m1_htrans = 2'b00;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_hwdata = '0; m1_hwdata = '0;
    s_hready = 1'b1; s_hrdata = '0;
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    m_hbusreq = 2'b11; m0_htrans = 2'b10; m0_haddr = 32'h55; m0_hwrite = 1'b1;
    m1_htrans = 2'b10; m1_haddr = 32'h66; m0_hwdata = 32'h77; s_hready = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (m_hgrant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b want 00", m_hgrant); end
    checks++; if (data_owner !== 2'b00) begin errs++; $display("FAIL reset_owner: got %b want 00", data_owner); end
    checks++; if (s_htrans !== 2'b00) begin errs++; $display("FAIL reset_htrans: got %b want 00", s_htrans); end
    checks++; if (s_haddr !== 32'h0) begin errs++; $display("FAIL reset_haddr: got %h want 0", s_haddr); end
    checks++; if (s_hwdata !== 32'h0) begin errs++; $display("FAIL reset_hwdata: got %h want 0", s_hwdata); end
  endtask

  task automatic test_single();
    do_reset();
    m_hbusreq = 2'b01; m0_hwrite = 1'b1;
    #1;
    checks++; if (m_hgrant !== 2'b00) begin errs++; $display("FAIL single_pregrant: got %b want 00", m_hgrant); end
    for (int k = 0; k < 6; k++) begin
      @(posedge HCLK); #1;
      m0_htrans = (k < 5) ? 2'b10 : 2'b00;
      m0_haddr  = 32'(k);
      m0_hwdata = (k > 0) ? 32'(32'hA0 + k - 1) : 32'h0;
      #1;
      if (k == 0) begin
        checks++; if (m_hgrant !== 2'b01) begin errs++; $display("FAIL single_grant: got %b want 01", m_hgrant); end
      end
      if (k < 5) begin
        checks++; if (s_haddr !== 32'(k)) begin errs++; $display("FAIL single_haddr[%0d]: got %h want %h", k, s_haddr, k); end
      end
      if (k > 0) begin
        checks++; if (s_hwdata !== 32'(32'hA0 + k - 1)) begin errs++; $display("FAIL single_hwdata[%0d]: got %h want %h", k, s_hwdata, 32'hA0 + k - 1); end
        checks++; if (data_owner !== 2'b01) begin errs++; $display("FAIL single_owner[%0d]: got %b want 01", k, data_owner); end
      end
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    do_reset();
    m_hbusreq = 2'b11;
    m0_htrans = 2'b10; m0_haddr = 32'h100;
    m1_htrans = 2'b10; m1_haddr = 32'h200;
    for (int i = 0; i < 12; i++) begin
      @(posedge HCLK); #1;
      exp = (((i / MAXB) % 2) == 0) ? 2'b01 : 2'b10;
      checks++; if (m_hgrant !== exp) begin errs++; $display("FAIL tie_grant[%0d]: got %b want %b", i, m_hgrant, exp); end
      checks++; if (s_haddr !== ((exp == 2'b01) ? 32'h100 : 32'h200)) begin errs++; $display("FAIL tie_haddr[%0d]: got %h", i, s_haddr); end
    end
  endtask

  task automatic test_wait();
    do_reset();
    m_hbusreq = 2'b11;
    m0_htrans = 2'b10; m0_haddr = 32'h100;
    m1_htrans = 2'b10; m1_haddr = 32'h200;
    repeat (4) @(posedge HCLK);
    #1;
    checks++; if (m_hgrant !== 2'b01) begin errs++; $display("FAIL wait_pre_grant: got %b want 01", m_hgrant); end
    s_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      checks++; if (m_hgrant !== 2'b01) begin errs++; $display("FAIL wait_grant[%0d]: got %b want 01", i, m_hgrant); end
      checks++; if (data_owner !== 2'b01) begin errs++; $display("FAIL wait_owner[%0d]: got %b want 01", i, data_owner); end
      checks++; if (s_haddr !== 32'h100) begin errs++; $display("FAIL wait_haddr[%0d]: got %h want 100", i, s_haddr); end
    end
    s_hready = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (m_hgrant !== 2'b10) begin errs++; $display("FAIL wait_handover: got %b want 10", m_hgrant); end
    checks++; if (data_owner !== 2'b01) begin errs++; $display("FAIL wait_last_owner: got %b want 01", data_owner); end
    @(posedge HCLK); #1;
    checks++; if (data_owner !== 2'b10) begin errs++; $display("FAIL wait_new_owner: got %b want 10", data_owner); end
  endtask

  task automatic test_drop();
    do_reset();
    m_hbusreq = 2'b01; m0_hwrite = 1'b1;
    @(posedge HCLK); #1;
    m0_htrans = 2'b10; m0_haddr = 32'h0;
    @(posedge HCLK); #1;
    m0_haddr = 32'h4; m0_hwdata = 32'hB0;
    @(posedge HCLK); #1;
    m0_haddr = 32'h8; m0_hwdata = 32'hB1; m_hbusreq = 2'b00;
    #1;
    checks++; if (m_hgrant !== 2'b01) begin errs++; $display("FAIL drop_still_owner: got %b want 01", m_hgrant); end
    @(posedge HCLK); #1;
    m0_htrans = 2'b00; m0_hwdata = 32'hB2;
    #1;
    checks++; if (m_hgrant !== 2'b00) begin errs++; $display("FAIL drop_grant: got %b want 00", m_hgrant); end
    checks++; if (s_htrans !== 2'b00) begin errs++; $display("FAIL drop_htrans: got %b want 00", s_htrans); end
    checks++; if (data_owner !== 2'b01) begin errs++; $display("FAIL drop_owner: got %b want 01", data_owner); end
    checks++; if (s_hwdata !== 32'hB2) begin errs++; $display("FAIL drop_hwdata: got %h want B2", s_hwdata); end
    @(posedge HCLK); #1;
    checks++; if (data_owner !== 2'b00) begin errs++; $display("FAIL drop_owner_clear: got %b want 00", data_owner); end
    checks++; if (s_hwdata !== 32'h0) begin errs++; $display("FAIL drop_hwdata_clear: got %h want 0", s_hwdata); end
  endtask

  task automatic test_read();
    do_reset();
    m_hbusreq = 2'b10;
    @(posedge HCLK); #1;
    m1_htrans = 2'b10; m1_haddr = 32'h3; m1_hwrite = 1'b0;
    #1;
    checks++; if (m_hgrant !== 2'b10) begin errs++; $display("FAIL read_grant: got %b want 10", m_hgrant); end
    checks++; if (s_haddr !== 32'h3 || s_hwrite !== 1'b0) begin errs++; $display("FAIL read_addr: got %h/%b want 3/0", s_haddr, s_hwrite); end
    @(posedge HCLK); #1;
    m1_htrans = 2'b00; m_hbusreq = 2'b00; s_hrdata = 32'hDEADBEEF;
    #1;
    checks++; if (m_hrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL read_hrdata: got %h want DEADBEEF", m_hrdata); end
    checks++; if (data_owner !== 2'b10) begin errs++; $display("FAIL read_owner: got %b want 10", data_owner); end
    checks++; if (m_hready !== 1'b1) begin errs++; $display("FAIL read_hready: got %b want 1", m_hready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m_hbusreq = 2'b10; m1_hwrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #1;
      m1_htrans = 2'b10; m1_haddr = 32'(32'h40 + 4 * k); m1_hwdata = 32'(32'hC0 + k);
    end
    #1;
    checks++; if (m_hgrant !== 2'b10 || data_owner !== 2'b10) begin errs++; $display("FAIL areset_pre: got %b/%b want 10/10", m_hgrant, data_owner); end
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (m_hgrant !== 2'b00) begin errs++; $display("FAIL areset_grant: got %b want 00", m_hgrant); end
    checks++; if (s_htrans !== 2'b00) begin errs++; $display("FAIL areset_htrans: got %b want 00", s_htrans); end
    checks++; if (data_owner !== 2'b00) begin errs++; $display("FAIL areset_owner: got %b want 00", data_owner); end
    checks++; if (s_hwdata !== 32'h0) begin errs++; $display("FAIL areset_hwdata: got %h want 0", s_hwdata); end
  endtask

  // Model: mg/mown are master indices (-1 = none), mcnt beats taken by mg,
  // mlast the master most recently handed the bus.
  task automatic test_random();
    int mg, mown, mcnt, mlast, ng, t, beats;
    bit act;
    logic [1:0]  eg, eo, et;
    logic [31:0] ea, ed;
    logic        ew;
    do_reset();
    mg = -1; mown = -1; mcnt = 0; mlast = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (s_hready) begin
        t   = (mg == 0) ? int'(m0_htrans) : (mg == 1) ? int'(m1_htrans) : 0;
        act = (mg >= 0) && (t >= 2);
        beats = mcnt + (act ? 1 : 0);
        mown = act ? mg : -1;
        if (m_hbusreq == 2'b00)      ng = -1;
        else if (m_hbusreq == 2'b01) ng = 0;
        else if (m_hbusreq == 2'b10) ng = 1;
        else if (mg >= 0 && beats < MAXB) ng = mg;
        else ng = 1 - mlast;
        if (ng != mg) begin
          mcnt = 0;
          if (ng >= 0) mlast = ng;
        end else begin
          mcnt = (beats > MAXB) ? MAXB : beats;
        end
        mg = ng;
      end
      @(posedge HCLK); #1;
      eg = (mg < 0) ? 2'b00 : 2'(1 << mg);
      eo = (mown < 0) ? 2'b00 : 2'(1 << mown);
      checks++; if (m_hgrant !== eg) begin errs++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, m_hgrant, eg); end
      checks++; if (data_owner !== eo) begin errs++; $display("FAIL rand_owner[%0d]: got %b want %b", cyc, data_owner, eo); end
      if (s_hready) begin
        m0_htrans = 2'($urandom_range(0, 3)); m1_htrans = 2'($urandom_range(0, 3));
        m0_haddr = $urandom; m1_haddr = $urandom;
        m0_hwrite = 1'($urandom_range(0, 1)); m1_hwrite = 1'($urandom_range(0, 1));
        m0_hwdata = $urandom; m1_hwdata = $urandom;
      end
      m_hbusreq = 2'($urandom_range(0, 3));
      s_hready  = ($urandom_range(0, 3) != 0);
      s_hrdata  = $urandom;
      #1;
      ea = (mg == 0) ? m0_haddr : (mg == 1) ? m1_haddr : 32'h0;
      et = (mg == 0) ? m0_htrans : (mg == 1) ? m1_htrans : 2'b00;
      ew = (mg == 0) ? m0_hwrite : (mg == 1) ? m1_hwrite : 1'b0;
      ed = (mown == 0) ? m0_hwdata : (mown == 1) ? m1_hwdata : 32'h0;
      checks++; if (s_haddr !== ea || s_htrans !== et || s_hwrite !== ew) begin
        errs++; $display("FAIL rand_addr[%0d]: got %h/%b/%b want %h/%b/%b", cyc, s_haddr, s_htrans, s_hwrite, ea, et, ew);
      end
      checks++; if (s_hwdata !== ed) begin errs++; $display("FAIL rand_hwdata[%0d]: got %h want %h", cyc, s_hwdata, ed); end
      checks++; if (m_hrdata !== s_hrdata || m_hready !== s_hready) begin
        errs++; $display("FAIL rand_bcast[%0d]: got %h/%b want %h/%b", cyc, m_hrdata, m_hready, s_hrdata, s_hready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_wait();
    test_drop();
    test_read();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
